// File: rtl/cpu_run_ctrl.sv
// Byte-stream program loader and run/halt/step sequencer for the RV32 core.
// All outputs registered; loader is valid/ready, one byte per cycle, imem write one cycle after the last byte of a word.
module cpu_run_ctrl #(
  parameter int                IMEM_DEPTH = 4096,
  parameter int                ADDR_W     = 12,
  parameter logic [ADDR_W-1:0] PC_LIMIT   = 12'd4095,
  parameter int                RST_HOLD   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic              abort_req,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              cpu_en,
  output logic              halted,
  output logic [2:0]        state,
  output logic [ADDR_W:0]   words_loaded,
  output logic              err_ovf
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RSTC = 3'd2,
    S_RUN  = 3'd3,
    S_HALT = 3'd4,
    S_STEP = 3'd5
  } state_t;

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [HW-1:0]     r_hold;
  logic [1:0]        r_lane;
  logic [31:0]       r_buf;
  logic [ADDR_W:0]   r_words;
  logic              r_err;
  logic              r_ld_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic              r_cpu_rst_n;
  logic              r_cpu_en;
  logic              r_halted;

  logic              w_idle;
  logic              w_acc;
  logic              w_full;
  logic              w_wr;
  logic [1:0]        w_lane;
  logic [ADDR_W:0]   w_words;
  logic [31:0]       w_word;
  logic              w_ld_ready_nxt;
  logic              w_cpu_rst_n_nxt;
  logic              w_cpu_en_nxt;
  logic              w_halted_nxt;

  // A byte taken in IDLE starts a fresh program: lane, word count and buffer act as zero.
  assign w_idle  = (r_state == S_IDLE);
  assign w_acc   = ld_valid & r_ld_ready & ~abort_req;
  assign w_lane  = w_idle ? 2'd0 : r_lane;
  assign w_words = w_idle ? '0 : r_words;
  assign w_full  = (w_words == (ADDR_W+1)'(IMEM_DEPTH));
  assign w_word  = (w_idle ? 32'd0 : r_buf) | ({24'd0, ld_byte} << {w_lane, 3'b000});
  assign w_wr    = w_acc & ~w_full & (ld_last | (w_lane == 2'd3));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_ld_ready  <= 1'b0;
      r_cpu_rst_n <= 1'b0;
      r_cpu_en    <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold      <= (r_state == S_RSTC && w_state_nxt == S_RSTC) ? r_hold + 1'b1 : '0;
      r_ld_ready  <= w_ld_ready_nxt;
      r_cpu_rst_n <= w_cpu_rst_n_nxt;
      r_cpu_en    <= w_cpu_en_nxt;
      r_halted    <= w_halted_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort_req) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc)        w_state_nxt = ld_last ? S_IDLE : S_LOAD;
          else if (run_req) w_state_nxt = S_RSTC;
        end
        S_LOAD: if (w_acc && ld_last) w_state_nxt = S_IDLE;
        S_RSTC: if (r_hold == HW'(RST_HOLD - 1)) w_state_nxt = S_RUN;
        S_RUN:  if (halt_req || (cpu_pc > PC_LIMIT)) w_state_nxt = S_HALT;
        S_HALT: begin
          if (!halt_req) begin
            if (step_req)     w_state_nxt = S_STEP;
            else if (run_req) w_state_nxt = S_RUN;
          end
        end
        S_STEP:  w_state_nxt = S_HALT;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they flop in with the state itself.
  always_comb begin
    w_ld_ready_nxt  = 1'b0;
    w_cpu_rst_n_nxt = 1'b0;
    w_cpu_en_nxt    = 1'b0;
    w_halted_nxt    = 1'b0;
    case (w_state_nxt)
      S_IDLE, S_LOAD: w_ld_ready_nxt = 1'b1;
      S_RSTC:         w_cpu_en_nxt = 1'b1;
      S_RUN, S_STEP: begin
        w_cpu_rst_n_nxt = 1'b1;
        w_cpu_en_nxt    = 1'b1;
      end
      S_HALT: begin
        w_cpu_rst_n_nxt = 1'b1;
        w_halted_nxt    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lane  <= 2'd0;
      r_buf   <= 32'd0;
      r_words <= '0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= 32'd0;
    end else begin
      r_we <= w_wr;
      if (abort_req) begin
        r_lane <= 2'd0;
        r_buf  <= 32'd0;
      end else if (w_acc) begin
        r_words <= w_wr ? w_words + 1'b1 : w_words;
        if (w_full)      r_err <= 1'b1;
        else if (w_idle) r_err <= 1'b0;
        if (w_wr) begin
          r_waddr <= w_words[ADDR_W-1:0];
          r_wdata <= w_word;
        end
        if (w_wr || ld_last) begin
          r_lane <= 2'd0;
          r_buf  <= 32'd0;
        end else if (!w_full) begin
          r_lane <= w_lane + 2'd1;
          r_buf  <= w_word;
        end
      end
    end
  end

  assign ld_ready     = r_ld_ready;
  assign imem_we      = r_we;
  assign imem_waddr   = r_waddr;
  assign imem_wdata   = r_wdata;
  assign cpu_rst_n    = r_cpu_rst_n;
  assign cpu_en       = r_cpu_en;
  assign halted       = r_halted;
  assign state        = r_state;
  assign words_loaded = r_words;
  assign err_ovf      = r_err;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios with literal expectations plus a randomized run,
// all outputs compared every cycle against a queue-based reference model.
module tb_cpu_run_ctrl;
  localparam int             AW    = 12;
  localparam int             DEPTH = 4;
  localparam logic [AW-1:0]  LIMIT = 12'd30;
  localparam int             HOLD  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, ld_valid, ld_last, run_req, halt_req, step_req, abort_req;
  logic [7:0]    ld_byte;
  logic [AW-1:0] cpu_pc;
  logic          ld_ready, imem_we, cpu_rst_n, cpu_en, halted, err_ovf;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic [2:0]    state;
  logic [AW:0]   words_loaded;

  cpu_run_ctrl #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW), .PC_LIMIT(LIMIT), .RST_HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
    .ld_ready(ld_ready), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
    .abort_req(abort_req), .cpu_pc(cpu_pc), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .cpu_rst_n(cpu_rst_n), .cpu_en(cpu_en), .halted(halted),
    .state(state), .words_loaded(words_loaded), .err_ovf(err_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: modes use the published state codes, the word in progress is a byte queue.
  int              m_mode  = 0;
  bit              m_ready = 0;
  bit              m_we    = 0;
  bit              m_err   = 0;
  int              m_words = 0;
  int              m_hold  = 0;
  logic [AW-1:0]   m_waddr = '0;
  logic [31:0]     m_wdata = '0;
  byte unsigned    m_bytes[$];
  bit              chk_en  = 0;
  logic [AW-1:0]   wr_a[$];
  logic [31:0]     wr_d[$];

  task automatic take_byte();
    logic [31:0] w;
    if (m_words >= DEPTH) begin
      m_err = 1;
    end else begin
      m_bytes.push_back(ld_byte);
      if (m_bytes.size() == 4 || ld_last) begin
        w = 0;
        foreach (m_bytes[i]) w |= 32'(m_bytes[i]) << (8 * i);
        m_we    = 1;
        m_waddr = AW'(m_words);
        m_wdata = w;
        m_words++;
        m_bytes.delete();
      end
    end
    if (ld_last) m_bytes.delete();
  endtask

  task automatic model_step();
    bit acc;
    acc  = ld_valid && m_ready && !abort_req;
    m_we = 0;
    if (abort_req) begin
      m_mode = 0;
      m_bytes.delete();
    end else begin
      case (m_mode)
        0: if (acc) begin
             m_words = 0; m_err = 0; m_bytes.delete();
             take_byte();
             m_mode = ld_last ? 0 : 1;
           end else if (run_req) begin
             m_mode = 2; m_hold = HOLD;
           end
        1: if (acc) begin
             take_byte();
             if (ld_last) m_mode = 0;
           end
        2: begin
             m_hold--;
             if (m_hold == 0) m_mode = 3;
           end
        3: if (halt_req || cpu_pc > LIMIT) m_mode = 4;
        4: if (!halt_req) begin
             if (step_req) m_mode = 5;
             else if (run_req) m_mode = 3;
           end
        5: m_mode = 4;
        default: m_mode = 0;
      endcase
    end
    m_ready = (m_mode <= 1);
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_ready = 0; m_we = 0; m_err = 0; m_words = 0; m_hold = 0;
      m_waddr = '0; m_wdata = '0; m_bytes.delete();
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("state",        state,        m_mode);
      check("cpu_rst_n",    cpu_rst_n,    (m_mode >= 3 && m_mode <= 5));
      check("cpu_en",       cpu_en,       (m_mode == 2 || m_mode == 3 || m_mode == 5));
      check("halted",       halted,       (m_mode == 4));
      check("ld_ready",     ld_ready,     m_ready);
      check("imem_we",      imem_we,      m_we);
      check("imem_waddr",   imem_waddr,   m_waddr);
      check("imem_wdata",   imem_wdata,   m_wdata);
      check("words_loaded", words_loaded, m_words);
      check("err_ovf",      err_ovf,      m_err);
      if (imem_we === 1'b1) begin
        wr_a.push_back(imem_waddr);
        wr_d.push_back(imem_wdata);
      end
    end
  end

  task automatic clear_pulses();
    ld_valid = 0; ld_last = 0; run_req = 0; halt_req = 0; step_req = 0; abort_req = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    ld_valid = 1; ld_byte = b; ld_last = last;
    @(negedge clk);
    ld_valid = 0; ld_last = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : main
    logic [7:0] prog1 [8];
    logic [7:0] prog2 [5];
    int rst_cyc, en_cnt, en_pairs;
    bit prev_en;

    prog1 = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    prog2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    rst_n = 0; ld_byte = 0; cpu_pc = 0;
    clear_pulses();
    idle(3);
    chk_en = 1;
    @(negedge clk);
    check("rst_state", state, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_cpu_rst_n", cpu_rst_n, 0);
    check("rst_words", words_loaded, 0);
    rst_n = 1;
    @(negedge clk);
    check("post_rst_ld_ready", ld_ready, 1);

    // Two full words
    wr_a.delete(); wr_d.delete();
    foreach (prog1[i]) send_byte(prog1[i], i == 7);
    idle(2);
    check("p1_nwr", wr_a.size(), 2);
    if (wr_a.size() == 2) begin
      check("p1_a0", wr_a[0], 0);
      check("p1_d0", wr_d[0], 32'h00500013);
      check("p1_a1", wr_a[1], 1);
      check("p1_d1", wr_d[1], 32'h00100093);
    end
    check("p1_words", words_loaded, 2);
    check("p1_state", state, 0);

    // Partial trailing word
    wr_a.delete(); wr_d.delete();
    foreach (prog2[i]) send_byte(prog2[i], i == 4);
    idle(2);
    check("p2_nwr", wr_a.size(), 2);
    if (wr_a.size() == 2) begin
      check("p2_d0", wr_d[0], 32'hDDCCBBAA);
      check("p2_a1", wr_a[1], 1);
      check("p2_d1", wr_d[1], 32'h000000EE);
    end
    check("p2_words", words_loaded, 2);

    // Reset hold, run, auto-halt
    run_req = 1;
    @(negedge clk);
    run_req = 0;
    rst_cyc = 0;
    for (int i = 0; i < 6; i++) begin
      if (state == 3'd3) break;
      if (cpu_rst_n === 1'b0 && cpu_en === 1'b1) rst_cyc++;
      @(negedge clk);
    end
    check("rstc_cycles", rst_cyc, 2);
    check("run_state", state, 3);
    check("run_cpu_rst_n", cpu_rst_n, 1);
    for (int i = 0; i < 32; i++) begin
      cpu_pc = AW'(i);
      @(negedge clk);
      if (i == 30) check("pc30_running", state, 3);
    end
    check("autohalt_state", state, 4);
    check("autohalt_en", cpu_en, 0);
    cpu_pc = 0;

    // Single steps
    en_cnt = 0; en_pairs = 0; prev_en = 0;
    for (int k = 0; k < 3; k++) begin
      step_req = 1;
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        step_req = 0;
        if (cpu_en === 1'b1) begin
          en_cnt++;
          if (prev_en) en_pairs++;
        end
        prev_en = (cpu_en === 1'b1);
        if (j == 3) check("halted_between_steps", halted, 1);
      end
    end
    check("step_en_cycles", en_cnt, 3);
    check("step_en_adjacent", en_pairs, 0);
    halt_req = 1; run_req = 1;
    @(negedge clk);
    clear_pulses();
    check("halt_wins_state", state, 4);
    run_req = 1;
    @(negedge clk);
    run_req = 0;
    check("resume_state", state, 3);
    check("resume_no_reset", cpu_rst_n, 1);
    halt_req = 1;
    @(negedge clk);
    halt_req = 0;
    check("halt_req_en", cpu_en, 0);
    abort_req = 1;
    @(negedge clk);
    abort_req = 0;
    check("abort_from_halt", state, 0);

    // Overflow past IMEM_DEPTH
    wr_a.delete(); wr_d.delete();
    for (int i = 1; i <= 20; i++) begin
      send_byte(8'(i), i == 20);
      if (i == 16) check("ovf_b16", err_ovf, 0);
      if (i == 17) check("ovf_b17", err_ovf, 1);
    end
    idle(2);
    check("ovf_nwr", wr_a.size(), 4);
    check("ovf_words", words_loaded, 4);
    check("ovf_state", state, 0);
    wr_a.delete(); wr_d.delete();
    send_byte(8'h11, 0);
    check("ovf_clear", err_ovf, 0);
    check("ovf_restart_words", words_loaded, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 1);
    idle(2);
    check("restart_nwr", wr_a.size(), 1);
    if (wr_a.size() == 1) check("restart_d0", wr_d[0], 32'h44332211);

    // Abort mid-word
    wr_a.delete(); wr_d.delete();
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    abort_req = 1;
    @(negedge clk);
    abort_req = 0;
    check("abort_state", state, 0);
    check("abort_we", imem_we, 0);
    idle(2);
    check("abort_nwr", wr_a.size(), 0);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), i == 4);
    idle(2);
    check("after_abort_nwr", wr_a.size(), 1);
    if (wr_a.size() == 1) begin
      check("after_abort_a0", wr_a[0], 0);
      check("after_abort_d0", wr_d[0], 32'h04030201);
    end

    // Reset mid-load
    wr_a.delete(); wr_d.delete();
    send_byte(8'h77, 0);
    send_byte(8'h88, 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check("midrst_state", state, 0);
    check("midrst_ready", ld_ready, 0);
    idle(2);
    check("midrst_nwr", wr_a.size(), 0);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(299) != 0);
      ld_valid  = $urandom_range(1);
      ld_byte   = 8'($urandom);
      ld_last   = ($urandom_range(7) == 0);
      run_req   = ($urandom_range(9) == 0);
      halt_req  = ($urandom_range(11) == 0);
      step_req  = ($urandom_range(7) == 0);
      abort_req = ($urandom_range(49) == 0);
      cpu_pc    = AW'($urandom_range(34));
      @(negedge clk);
    end
    clear_pulses();
    rst_n = 1;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
